// File: rtl/pipe_pkg.sv
// Shared definitions for miniRV pipeline stage registers: state encodings,
// default payload widths and control-field bit positions used by stage instantiators.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 32;

    // Control payload layout packed by stage instantiators into in_ctrl
    localparam int CTRL_RF_WE       = 0;
    localparam int CTRL_RAM_WE      = 1;
    localparam int CTRL_RF_WSEL_LSB = 2;
    localparam int CTRL_RF_WSEL_MSB = 3;
    localparam int CTRL_RW_OP_LSB   = 4;
    localparam int CTRL_RW_OP_MSB   = 6;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: increments by one while en is high, sticks at all-ones,
// cleared only by the asynchronous reset.
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake, 2-entry skid buffer, synchronous flush
// and bubble-masked control. Optional perf counters enabled by `define PIPE_STAGE_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = DEF_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic [1:0]        state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // main payload is left untouched so out_data stays stable while empty
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state     <= ST_ONE;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (in_valid) begin
                        state     <= ST_FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end else if (out_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != ST_FULL);
        out_valid = (state != ST_EMPTY);
        out_data  = main_data;
        out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .en (out_valid && !out_ready),
        .cnt(stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .rst(rst),
        .en (!out_valid),
        .cnt(bubble_cnt)
    );
`endif

endmodule
